// File: rtl/measurement_scheduler_if.sv
// Command path between the scheduler, the UART receiver and the sensor crossbar.
// The slave view belongs to the scheduler; the master view drives it.
interface measurement_scheduler_if;
   logic [7:0] host_cmd;
   logic       host_cmd_valid;
   logic       xbar_ready;
   logic [7:0] xbar_cmd;
   logic       xbar_cmd_valid;

   modport master (
      output host_cmd, host_cmd_valid, xbar_ready,
      input  xbar_cmd, xbar_cmd_valid
   );

   modport slave (
      input  host_cmd, host_cmd_valid, xbar_ready,
      output xbar_cmd, xbar_cmd_valid
   );
endinterface

// File: rtl/measurement_scheduler.sv
// Merges host command bytes with a periodic auto-measurement tick and issues
// one command at a time to the sensor crossbar, with a completion watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing outstanding; pick host (first) or auto command
// ISSUE     | one-cycle command strobe to the crossbar
// WAIT_ACK  | waiting for the crossbar to drop ready (command latched)
// WAIT_DONE | waiting for the crossbar to raise ready (command finished)
module measurement_scheduler #(
   parameter int PERIOD_CYCLES  = 100_000_000,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   measurement_scheduler_if.slave  bus,
   input  logic                    auto_en,
   input  logic                    err_clear,
   output logic                    busy,
   output logic                    host_drop,
   output logic                    timeout_err,
   output logic                    overrun_err
);
   localparam int TMR_W = $clog2(PERIOD_CYCLES);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(PERIOD_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_TC  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] CMD_T = 8'h54;
   localparam logic [7:0] CMD_D = 8'h44;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
   state_t state, state_nxt;

   logic [TMR_W-1:0] tmr;
   logic [WD_W-1:0]  wd;
   logic             wd_expired;
   logic             host_pending;
   logic [7:0]       host_byte;
   logic             auto_pending;
   logic             auto_sel_d;
   logic             host_legal;
   logic             auto_tick;
   logic             waiting;
   logic             wd_fire;
   logic             take_host;
   logic             take_auto;
   logic [7:0]       cmd_nxt;

   assign host_legal = (bus.host_cmd == CMD_T) || (bus.host_cmd == CMD_D);
   assign auto_tick  = auto_en && (tmr == TMR_TC);
   assign waiting    = (state == WAIT_ACK) || (state == WAIT_DONE);
   // fires once per issued command; wd_expired stops a re-fire while stuck in WAIT_DONE
   assign wd_fire    = waiting && (wd == WD_TC) && !wd_expired;

   always_comb begin
      state_nxt = state;
      take_host = 1'b0;
      take_auto = 1'b0;
      cmd_nxt   = bus.xbar_cmd;
      case (state)
         IDLE: begin
            if (bus.xbar_ready) begin
               if (host_pending) begin
                  take_host = 1'b1;
                  cmd_nxt   = host_byte;
                  state_nxt = ISSUE;
               end else if (auto_pending) begin
                  take_auto = 1'b1;
                  cmd_nxt   = auto_sel_d ? CMD_D : CMD_T;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE:     state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (!bus.xbar_ready) begin
               state_nxt = WAIT_DONE;
            end else if (wd_fire) begin
               state_nxt = IDLE;
            end
         end
         WAIT_DONE: begin
            if (bus.xbar_ready) begin
               state_nxt = IDLE;
            end
         end
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         bus.xbar_cmd       <= 8'h00;
         bus.xbar_cmd_valid <= 1'b0;
         busy               <= 1'b0;
         host_drop          <= 1'b0;
         host_pending       <= 1'b0;
         host_byte          <= 8'h00;
         tmr                <= '0;
         auto_pending       <= 1'b0;
         auto_sel_d         <= 1'b0;
         wd                 <= '0;
         wd_expired         <= 1'b0;
         timeout_err        <= 1'b0;
         overrun_err        <= 1'b0;
      end else begin
         state              <= state_nxt;
         bus.xbar_cmd       <= cmd_nxt;
         bus.xbar_cmd_valid <= (state_nxt == ISSUE);
         busy               <= (state_nxt != IDLE);
         host_drop          <= bus.host_cmd_valid && (!host_legal || host_pending);

         if (take_host) begin
            host_pending <= 1'b0;
         end else if (bus.host_cmd_valid && host_legal && !host_pending) begin
            host_pending <= 1'b1;
            host_byte    <= bus.host_cmd;
         end

         if (!auto_en) begin
            tmr          <= '0;
            auto_pending <= 1'b0;
         end else begin
            tmr <= auto_tick ? '0 : tmr + 1'b1;
            if (auto_tick) begin
               auto_pending <= 1'b1;
            end else if (take_auto) begin
               auto_pending <= 1'b0;
            end
         end
         if (take_auto) begin
            auto_sel_d <= ~auto_sel_d;
         end

         if (state == ISSUE) begin
            wd         <= '0;
            wd_expired <= 1'b0;
         end else if (wd_fire) begin
            wd_expired <= 1'b1;
         end else if (waiting && (wd != WD_TC)) begin
            wd <= wd + 1'b1;
         end

         // a set in the same cycle as err_clear takes priority
         if (wd_fire) begin
            timeout_err <= 1'b1;
         end else if (err_clear) begin
            timeout_err <= 1'b0;
         end
         if (auto_tick && auto_pending) begin
            overrun_err <= 1'b1;
         end else if (err_clear) begin
            overrun_err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_measurement_scheduler.sv
// Self-checking bench for measurement_scheduler with a behavioural crossbar
// and expected command order/timing derived from the scheduling rules.
module tb_measurement_scheduler;
   localparam int PERIOD = 16;
   localparam int TMO    = 8;

   logic clk, rst, auto_en, err_clear;
   logic busy, host_drop, timeout_err, overrun_err;
   int   checks, errors, cyc, drop_cnt;
   logic [7:0] obs_cmd[$];
   int         obs_cyc[$];
   int   xb_ack, xb_done;
   bit   xb_hold, xb_no_ack;

   measurement_scheduler_if xif ();

   measurement_scheduler #(.PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .bus(xif), .auto_en(auto_en), .err_clear(err_clear),
      .busy(busy), .host_drop(host_drop), .timeout_err(timeout_err), .overrun_err(overrun_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // crossbar: drops ready xb_ack edges after the strobe, raises it xb_done edges later
   initial begin
      xif.xbar_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (xif.xbar_cmd_valid && !xb_no_ack) begin
            repeat (xb_ack) @(posedge clk);
            #1 xif.xbar_ready = 1'b0;
            repeat (xb_done) @(posedge clk);
            while (xb_hold) @(posedge clk);
            #1 xif.xbar_ready = 1'b1;
         end
      end
   end

   initial begin
      drop_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst && xif.xbar_cmd_valid) begin
            obs_cmd.push_back(xif.xbar_cmd);
            obs_cyc.push_back(cyc);
         end
         if (host_drop) drop_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "bench time limit");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      xif.host_cmd       = b;
      xif.host_cmd_valid = 1'b1;
      step(1);
      xif.host_cmd_valid = 1'b0;
   endtask

   task automatic clear_obs();
      obs_cmd.delete();
      obs_cyc.delete();
      drop_cnt = 0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!busy && xif.xbar_ready) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; auto_en = 1'b0; err_clear = 1'b0;
      xif.host_cmd = 8'h00; xif.host_cmd_valid = 1'b0;
      xb_hold = 1'b0; xb_no_ack = 1'b0; xb_ack = 3; xb_done = 4;
      for (int i = 0; i < 50 && !xif.xbar_ready; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      clear_obs();
   endtask

   task automatic test_reset();
      checks++; if (xif.xbar_cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd got %0h want 00", xif.xbar_cmd); end
      checks++; if (xif.xbar_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", xif.xbar_cmd_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (host_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b want 0", host_drop); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", timeout_err); end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun_err); end
   endtask

   task automatic test_host_issue();
      logic [7:0] b;
      int e0, nbusy;
      for (int it = 0; it < 6; it++) begin
         b = ($urandom_range(0, 1) == 1) ? 8'h54 : 8'h44;
         xb_ack  = $urandom_range(1, 3);
         xb_done = $urandom_range(1, 4);
         clear_obs();
         strobe(b);
         e0 = cyc;
         checks++; if (xif.xbar_cmd_valid !== 1'b0) begin errors++; $display("FAIL host_early_valid got %0b want 0", xif.xbar_cmd_valid); end
         nbusy = 0;
         for (int i = 0; i < 40; i++) begin
            step(1);
            if (busy) nbusy++;
            else if (nbusy > 0) break;
         end
         checks++;
         if (obs_cmd.size() != 1) begin
            errors++; $display("FAIL host_issue_count got %0d want 1", obs_cmd.size());
         end else begin
            checks++; if (obs_cmd[0] !== b) begin errors++; $display("FAIL host_issue_cmd got %0h want %0h", obs_cmd[0], b); end
            checks++; if (obs_cyc[0] != e0 + 1) begin errors++; $display("FAIL host_issue_latency got %0d want %0d", obs_cyc[0] - e0, 1); end
         end
         checks++; if (nbusy != xb_ack + xb_done + 1) begin errors++; $display("FAIL host_busy_len got %0d want %0d", nbusy, xb_ack + xb_done + 1); end
         checks++; if (xif.xbar_cmd !== b) begin errors++; $display("FAIL host_cmd_hold got %0h want %0h", xif.xbar_cmd, b); end
         checks++; if (timeout_err !== 1'b0 || drop_cnt != 0) begin errors++; $display("FAIL host_no_side_effects got to=%0b drops=%0d want 0 0", timeout_err, drop_cnt); end
         step(2);
      end
   endtask

   task automatic test_illegal();
      logic [7:0] b;
      for (int it = 0; it < 4; it++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'h54 || b == 8'h44) b = 8'h41;
         clear_obs();
         strobe(b);
         checks++; if (host_drop !== 1'b1) begin errors++; $display("FAIL illegal_drop got %0b want 1 byte %0h", host_drop, b); end
         step(1);
         checks++; if (host_drop !== 1'b0) begin errors++; $display("FAIL illegal_drop_width got %0b want 0", host_drop); end
         step(5);
         checks++; if (obs_cmd.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL illegal_no_issue got n=%0d busy=%0b want 0 0", obs_cmd.size(), busy); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b1, b2, b3;
      int e0;
      bit ok;
      b1 = ($urandom_range(0, 1) == 1) ? 8'h54 : 8'h44;
      b2 = ($urandom_range(0, 1) == 1) ? 8'h54 : 8'h44;
      b3 = ($urandom_range(0, 1) == 1) ? 8'h54 : 8'h44;
      xb_ack = 3; xb_done = 4;
      clear_obs();
      strobe(b1);
      e0 = cyc;
      step(2);
      strobe(b2);
      strobe(b3);
      strobe(8'h54);
      step(30);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_idle got busy want idle"); end
      checks++;
      if (obs_cmd.size() != 2) begin
         errors++; $display("FAIL b2b_count got %0d want 2", obs_cmd.size());
      end else begin
         checks++; if (obs_cmd[0] !== b1 || obs_cmd[1] !== b2) begin errors++; $display("FAIL b2b_order got %0h %0h want %0h %0h", obs_cmd[0], obs_cmd[1], b1, b2); end
         checks++; if (obs_cyc[1] != e0 + 1 + xb_ack + xb_done + 2) begin errors++; $display("FAIL b2b_second_time got %0d want %0d", obs_cyc[1] - e0, 1 + xb_ack + xb_done + 2); end
      end
      checks++; if (drop_cnt != 2) begin errors++; $display("FAIL b2b_drops got %0d want 2", drop_cnt); end
   endtask

   task automatic test_auto();
      int p0;
      logic [7:0] exp;
      do_reset();
      xb_ack = 2; xb_done = 3;
      p0 = cyc;
      auto_en = 1'b1;
      step(52);
      checks++;
      if (obs_cmd.size() != 3) begin
         errors++; $display("FAIL auto_count got %0d want 3", obs_cmd.size());
      end else begin
         for (int n = 0; n < 3; n++) begin
            exp = (n % 2 == 0) ? 8'h54 : 8'h44;
            checks++; if (obs_cmd[n] !== exp) begin errors++; $display("FAIL auto_cmd%0d got %0h want %0h", n, obs_cmd[n], exp); end
            checks++; if (obs_cyc[n] != p0 + (n + 1) * PERIOD + 1) begin errors++; $display("FAIL auto_time%0d got %0d want %0d", n, obs_cyc[n] - p0, (n + 1) * PERIOD + 1); end
         end
      end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL auto_overrun got %0b want 0", overrun_err); end
      auto_en = 1'b0;
      step(40);
      checks++; if (obs_cmd.size() != 3) begin errors++; $display("FAIL auto_disable got %0d want 3", obs_cmd.size()); end
   endtask

   task automatic test_priority();
      int p0;
      do_reset();
      xb_ack = 2; xb_done = 3;
      p0 = cyc;
      auto_en = 1'b1;
      step(PERIOD - 1);
      strobe(8'h44);
      step(12);
      auto_en = 1'b0;
      step(20);
      checks++;
      if (obs_cmd.size() != 2) begin
         errors++; $display("FAIL prio_count got %0d want 2", obs_cmd.size());
      end else begin
         checks++; if (obs_cmd[0] !== 8'h44 || obs_cmd[1] !== 8'h54) begin errors++; $display("FAIL prio_order got %0h %0h want 44 54", obs_cmd[0], obs_cmd[1]); end
         checks++; if (obs_cyc[0] != p0 + PERIOD + 1) begin errors++; $display("FAIL prio_host_time got %0d want %0d", obs_cyc[0] - p0, PERIOD + 1); end
         checks++; if (obs_cyc[1] != obs_cyc[0] + xb_ack + xb_done + 2) begin errors++; $display("FAIL prio_auto_time got %0d want %0d", obs_cyc[1] - obs_cyc[0], xb_ack + xb_done + 2); end
      end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL prio_overrun got %0b want 0", overrun_err); end
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset();
      xb_ack = 1; xb_done = 1; xb_hold = 1'b1;
      strobe(8'h54);
      step(TMO + 1);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %0b want 0", timeout_err); end
      step(1);
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got %0b want 1", timeout_err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_stay_wait_done got busy %0b want 1", busy); end
      step(5);
      err_clear = 1'b1; step(1); err_clear = 1'b0;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %0b want 0", timeout_err); end
      step(12);
      checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_no_refire got to=%0b busy=%0b want 0 1", timeout_err, busy); end
      xb_hold = 1'b0;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_release got busy want idle"); end
      xb_hold = 1'b1;
      strobe(8'h44);
      step(TMO + 1);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_second_early got %0b want 0", timeout_err); end
      err_clear = 1'b1; step(1); err_clear = 1'b0;
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_beats_clear got %0b want 1", timeout_err); end
      err_clear = 1'b1; step(1); err_clear = 1'b0;
      xb_hold = 1'b0;
      wait_idle(ok);
      xb_no_ack = 1'b1;
      strobe(8'h54);
      step(TMO + 1);
      checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_ack_pre got busy=%0b to=%0b want 1 0", busy, timeout_err); end
      step(1);
      checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_ack_abort got busy=%0b to=%0b want 0 1", busy, timeout_err); end
      xb_no_ack = 1'b0;
   endtask

   task automatic test_overrun();
      int p0;
      bit ok;
      do_reset();
      xb_ack = 1; xb_done = 1; xb_hold = 1'b1;
      p0 = cyc;
      auto_en = 1'b1;
      step(3 * PERIOD - 1);
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_early got %0b want 0", overrun_err); end
      step(1);
      checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b want 1", overrun_err); end
      err_clear = 1'b1; step(1); err_clear = 1'b0;
      checks++; if (overrun_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL ovr_clear got ovr=%0b to=%0b want 0 0", overrun_err, timeout_err); end
      auto_en = 1'b0;
      xb_hold = 1'b0;
      wait_idle(ok);
      checks++; if (!ok || obs_cmd.size() != 1) begin errors++; $display("FAIL ovr_single_issue got n=%0d ok=%0b want 1 1", obs_cmd.size(), ok); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      xb_ack = 2; xb_done = 1; xb_hold = 1'b1;
      strobe(8'h54);
      step(5);
      strobe(8'h44);
      step(2);
      #2 rst = 1'b0;
      #1;
      checks++; if (xif.xbar_cmd !== 8'h00 || xif.xbar_cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cmd got %0h/%0b want 00/0", xif.xbar_cmd, xif.xbar_cmd_valid); end
      checks++; if (busy !== 1'b0 || host_drop !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b/%0b want 0/0", busy, host_drop); end
      checks++; if (timeout_err !== 1'b0 || overrun_err !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %0b/%0b want 0/0", timeout_err, overrun_err); end
      xb_hold = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      clear_obs();
      step(25);
      checks++; if (obs_cmd.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_pending_lost got n=%0d busy=%0b want 0 0", obs_cmd.size(), busy); end
      strobe(8'h44);
      step(2);
      wait_idle(ok);
      checks++; if (!ok || obs_cmd.size() != 1) begin errors++; $display("FAIL rstmid_recover got n=%0d want 1", obs_cmd.size()); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      do_reset();
      test_reset();
      test_host_issue();
      test_illegal();
      test_back_to_back();
      test_auto();
      test_priority();
      test_timeout();
      test_overrun();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
